// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM encoding, frame constants and the
// baud_select divisor table (50 MHz clock, 16x oversampling).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAME_BITS     = 11;
    localparam int BAUD_CNT_W     = 14;

    // Clock cycles per sample_ENABLE tick for each baud code.
    function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel);
        logic [BAUD_CNT_W-1:0] div;
        case (sel)
            3'b000:  div = 14'd10417; // 300
            3'b001:  div = 14'd2604;  // 1200
            3'b010:  div = 14'd1302;  // 2400
            3'b011:  div = 14'd651;   // 4800
            3'b100:  div = 14'd326;   // 9600
            3'b101:  div = 14'd163;   // 19200
            3'b110:  div = 14'd27;    // 115200
            default: div = 14'd54;    // 57600
        endcase
        return div;
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Free-running tick generator: one-cycle sample_ENABLE pulse every
// baud_divisor(baud_select) clocks.
module baud_controller
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [BAUD_CNT_W-1:0] div_last;
    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    assign div_last      = baud_divisor(baud_select) - BAUD_CNT_W'(1);
    // >= so switching to a faster rate mid-count wraps at once instead of overflowing
    assign sample_ENABLE = (cnt_q >= div_last);
    assign cnt_d         = sample_ENABLE ? '0 : cnt_q + BAUD_CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, 8 data (LSB first), 1 parity, 1 stop bit,
// each bit OVERSAMPLE baud ticks long; TxD and Tx_BUSY are registered.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter bit PARITY_EVEN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    tx_state_e  state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;

    logic       sample_ENABLE;
    logic       bit_end;
    logic [2:0] bit_nx;
    logic       parity;

    baud_controller u_baud (
        .reset         (reset),
        .clk           (clk),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_ENABLE)
    );

    assign bit_end = sample_ENABLE && (tick_q == TICK_LAST);
    assign bit_nx  = bit_q + 3'd1;
    assign parity  = (^data_q) ^ ~PARITY_EVEN;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        data_d  = data_q;
        txd_d   = txd_q;
        busy_d  = busy_q;

        if (state_q != IDLE && sample_ENABLE) begin
            tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                // Acceptance clears the tick counter even if a tick lands on this edge
                if (Tx_WR && Tx_EN) begin
                    data_d  = Tx_DATA;
                    tick_d  = 4'd0;
                    bit_d   = 3'd0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_d   = data_q[0];
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = parity;
                        state_d = PARITY;
                    end else begin
                        txd_d = data_q[bit_nx];
                        bit_d = bit_nx;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    bit_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                tick_d  = 4'd0;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter: a line receiver decodes TxD and
// compares each frame against a byte-queue scoreboard built from the frame rules.
module tb_uart_transmitter;

    localparam bit         PAR_EVEN = 1'b1;
    localparam int         OS       = 16;
    localparam logic [2:0] SEL_SLOW = 3'b111;
    localparam logic [2:0] SEL_FAST = 3'b110;
    localparam int         DIV_SLOW = 54;
    localparam int         DIV_FAST = 27;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    uart_transmitter #(
        .OVERSAMPLE  (OS),
        .PARITY_EVEN (PAR_EVEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line image of one frame, bit 0 sent first.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic p;
        p = ^d;
        if (!PAR_EVEN) p = ~p;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Wait for a start edge, then sample every bit near its middle.
    task automatic recv_frame(input int div, input string tag, output logic [10:0] got);
        int n;
        logic [7:0] d;
        got = '1;
        n   = 0;
        while (TxD !== 1'b0 && n < 20 * OS * div) begin
            @(negedge clk);
            n++;
        end
        if (TxD !== 1'b0) begin
            chk_eq({tag, "_start_timeout"}, 32'(TxD), 32'd0);
            return;
        end
        for (int k = 0; k < 11; k++) begin
            repeat ((k == 0) ? (OS / 2) * div : OS * div) @(negedge clk);
            got[k] = TxD;
        end
        if (exp_q.size() == 0) begin
            chk_eq({tag, "_unexpected_frame"}, 32'(got), 32'h7ff);
        end else begin
            d = exp_q.pop_front();
            chk_eq(tag, 32'(got), 32'(model_frame(d)));
        end
    endtask

    // Write strobe on one edge; Tx_DATA is scrambled right after to probe the latch.
    task automatic send(input logic [7:0] d, input bit expect_frame, input string tag);
        @(negedge clk);
        if (expect_frame) exp_q.push_back(d);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR   = 1'b0;
        Tx_DATA = 8'($urandom);
        chk_eq({tag, "_start_line"}, 32'({TxD, Tx_BUSY}), 32'b01);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n;
        n = 0;
        while (Tx_BUSY !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 32'({TxD, Tx_BUSY}), 32'b10);
    endtask

    initial begin
        logic [10:0] got;
        int          low0;
        int          busy_len;
        int          lo;
        int          hi;
        bit          bad;

        reset       = 1'b1;
        baud_select = SEL_SLOW;
        Tx_EN       = 1'b0;
        Tx_WR       = 1'b0;
        Tx_DATA     = 8'h00;
        repeat (4) @(negedge clk);
        chk_eq("reset_hold_line", 32'({TxD, Tx_BUSY}), 32'b10);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("after_reset_line", 32'({TxD, Tx_BUSY}), 32'b10);

        // Writes with the transmitter disabled must be ignored.
        bad = 1'b0;
        Tx_DATA = 8'h5A;
        Tx_WR   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        Tx_WR = 1'b0;
        chk_eq("en0_ignored", 32'(bad), 32'd0);
        Tx_EN = 1'b1;

        // 8'hA5 at 54 clk/tick, with start-bit and busy-window timing.
        fork
            begin
                recv_frame(DIV_SLOW, "frame_A5", got);
            end
            begin
                send(8'hA5, 1'b1, "A5");
                low0 = 1;
                busy_len = 0;
                while (TxD === 1'b0 && low0 < 2 * OS * DIV_SLOW) begin
                    @(negedge clk);
                    if (TxD === 1'b0) low0++;
                end
                busy_len = low0;
                while (Tx_BUSY === 1'b1 && busy_len < 12 * OS * DIV_SLOW) begin
                    @(negedge clk);
                    if (Tx_BUSY === 1'b1) busy_len++;
                end
            end
        join
        lo = (OS - 1) * DIV_SLOW + 1;
        hi = OS * DIV_SLOW;
        chk_eq("A5_start_len_ok", 32'(low0 >= lo && low0 <= hi), 32'd1);
        lo = (FRAME_LEN() - 1) * DIV_SLOW + 1;
        hi = FRAME_LEN() * DIV_SLOW;
        chk_eq("A5_busy_len_ok", 32'(busy_len >= lo && busy_len <= hi), 32'd1);
        wait_idle(OS * DIV_SLOW, "A5_idle");

        // Parity of 8'h07 under even parity.
        baud_select = SEL_FAST;
        fork
            recv_frame(DIV_FAST, "frame_07", got);
            send(8'h07, 1'b1, "07");
        join
        chk_eq("parity_07", 32'(got[9]), 32'd1);
        wait_idle(OS * DIV_FAST, "07_idle");

        // Mid-frame writes of 8'hFF, with Tx_EN dropped during data bits.
        fork
            recv_frame(DIV_FAST, "frame_3C", got);
            begin
                send(8'h3C, 1'b1, "3C");
                repeat (3 * OS * DIV_FAST) @(negedge clk);
                Tx_EN = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    Tx_DATA = 8'hFF;
                    Tx_WR   = 1'b1;
                    @(negedge clk);
                    Tx_WR   = 1'b0;
                    repeat (OS * DIV_FAST - 1) @(negedge clk);
                end
                Tx_EN = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    Tx_DATA = 8'hFF;
                    Tx_WR   = 1'b1;
                    @(negedge clk);
                    Tx_WR   = 1'b0;
                    repeat (OS * DIV_FAST - 1) @(negedge clk);
                end
            end
        join
        wait_idle(OS * DIV_FAST, "3C_idle");
        bad = 1'b0;
        for (int i = 0; i < 2 * OS * DIV_FAST; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        chk_eq("3C_no_second_frame", 32'(bad), 32'd0);

        // Back-to-back: second write on the cycle Tx_BUSY falls.
        fork
            begin
                recv_frame(DIV_FAST, "frame_55", got);
                recv_frame(DIV_FAST, "frame_AA", got);
            end
            begin
                send(8'h55, 1'b1, "55");
                wait_idle(12 * OS * DIV_FAST, "55_end");
                exp_q.push_back(8'hAA);
                Tx_DATA = 8'hAA;
                Tx_WR   = 1'b1;
                @(negedge clk);
                Tx_WR   = 1'b0;
                chk_eq("b2b_start_next_cycle", 32'({TxD, Tx_BUSY}), 32'b01);
            end
        join
        wait_idle(OS * DIV_FAST, "AA_idle");

        // Asynchronous reset in the middle of data bit 4.
        send(8'hE7, 1'b0, "E7");
        repeat ((5 * OS + OS / 2) * DIV_FAST) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_eq("async_reset_line", 32'({TxD, Tx_BUSY}), 32'b10);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("post_reset_idle", 32'({TxD, Tx_BUSY}), 32'b10);
        fork
            recv_frame(DIV_FAST, "frame_81", got);
            send(8'h81, 1'b1, "81");
        join
        wait_idle(OS * DIV_FAST, "81_idle");

        // Random bytes with random idle gaps.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            fork
                recv_frame(DIV_FAST, "frame_rand", got);
                send(d, 1'b1, "rand");
            join
            wait_idle(OS * DIV_FAST, "rand_idle");
        end

        // Baud change mid-frame must still terminate the frame.
        send(8'($urandom), 1'b0, "baudchg");
        repeat (3000) @(negedge clk);
        baud_select = SEL_SLOW;
        wait_idle(FRAME_LEN() * DIV_SLOW + 100, "baud_change_idle");

        chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic int FRAME_LEN();
        return 11 * OS;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
